iop_queue: RTL and testbench

Scheduling queue that consumes the decode unit's internal-operation stream (`id_feed` / `id_iop` / `id_iop_init`) and returns `hold` as backpressure. It buffers up to `DEPTH` iops in order. It walks the head iop through its execution steps (AGU, LOAD, ALU, STORE) with a req/ack handshake per functional unit, then retires it. It sits between decode and the AGU/ALU/memory datapath.

---
 rtl/iop_queue.sv | 130 +++++++++++++
 tb/tb_iop_queue.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iop_queue.sv
// iop_queue: in-order scheduling queue that walks the head iop through AGU/LOAD/ALU/STORE and retires it.
// Optional IOPQ_BYPASS_EN: an ALU-first iop pushed into an empty queue is presented to the ALU in the push cycle.
module iop_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_feed,
  input  logic [31:0] id_iop,
  input  logic [2:0]  id_iop_init,
  output logic        hold,
  input  logic        flush,
  output logic [31:0] iop_out,
  output logic        agu_req,
  input  logic        agu_ack,
  output logic        ld_req,
  input  logic        ld_ack,
  output logic        alu_req,
  input  logic        alu_ack,
  output logic        st_req,
  input  logic        st_ack,
  output logic        iop_retire,
  output logic        busy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // step | meaning
  // AGU  | address generation pending
  // LD   | load pending, width in iop[3]
  // ALU  | alu operation pending
  // ST   | store pending, rmw in iop[4]
  typedef enum logic [1:0] {S_AGU = 2'b00, S_LD = 2'b01, S_ALU = 2'b10, S_ST = 2'b11} step_t;

  logic [31:0]   mem_iop  [DEPTH];
  step_t         mem_step [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          retire_q;

  logic          accept, byp, head_vld, cur_ack, done, retire_now, pop, push_wr, adv;
  logic [31:0]   head_iop;
  step_t         head_step, next_step, init_step, push_step;

  assign busy   = (count != '0);
  assign hold   = (count == FULL);
  assign accept = id_feed & ~hold & id_iop_init[2];

  always_comb begin
    if (id_iop_init[0])      init_step = S_AGU;
    else if (id_iop_init[1]) init_step = S_ALU;
    else                     init_step = S_LD;
  end

`ifdef IOPQ_BYPASS_EN
  assign byp = ~busy & accept & ~rst & ~flush & (init_step == S_ALU);
`else
  assign byp = 1'b0;
`endif

  assign head_iop  = byp ? id_iop : mem_iop[rd_ptr];
  assign head_step = byp ? S_ALU : mem_step[rd_ptr];
  assign head_vld  = busy | byp;

  always_comb begin
    cur_ack   = 1'b0;
    next_step = head_step;
    done      = 1'b0;
    case (head_step)
      S_AGU: begin
        cur_ack   = agu_ack;
        next_step = (head_iop[22] & ~head_iop[4]) ? S_ALU : S_LD;
      end
      S_LD: begin
        cur_ack   = ld_ack;
        next_step = S_ALU;
      end
      S_ALU: begin
        cur_ack   = alu_ack;
        next_step = S_ST;
        done      = ~head_iop[22];
      end
      default: begin
        cur_ack = st_ack;
        done    = 1'b1;
      end
    endcase
  end

  assign retire_now = head_vld & cur_ack & done;
  assign adv        = busy & cur_ack & ~done;
  assign pop        = busy & retire_now;
  // a bypassed iop that finishes in its push cycle never occupies an entry
  assign push_wr    = accept & ~(byp & retire_now);
  assign push_step  = byp ? (cur_ack ? next_step : S_ALU) : init_step;

  assign iop_out    = head_vld ? head_iop : 32'h0;
  assign agu_req    = head_vld & (head_step == S_AGU);
  assign ld_req     = head_vld & (head_step == S_LD);
  assign alu_req    = head_vld & (head_step == S_ALU);
  assign st_req     = head_vld & (head_step == S_ST);
  assign iop_retire = retire_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      retire_q <= 1'b0;
    end else begin
      retire_q <= retire_now;
      if (push_wr) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      if (push_wr & ~pop)      count <= count + CW'(1);
      else if (~push_wr & pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (push_wr) begin
        mem_iop[wr_ptr]  <= id_iop;
        mem_step[wr_ptr] <= push_step;
      end
      if (adv) mem_step[rd_ptr] <= next_step;
    end
  end

endmodule

// File: tb/tb_iop_queue.sv
// tb_iop_queue: directed and random stimulus against a route-list queue model; a negedge monitor
// compares outputs every cycle and pops a scoreboard of expected step handshakes and retires.
module tb_iop_queue;
  localparam int DEPTH = 4;
  localparam int K_AGU = 0, K_LD = 1, K_ALU = 2, K_ST = 3, K_RET = 4, K_NONE = 5;
`ifdef IOPQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [31:0] iop;
    int          kind;
  } tok_t;

  logic        clk = 1'b0;
  logic        rst, id_feed, flush;
  logic [31:0] id_iop;
  logic [2:0]  id_iop_init;
  logic [3:0]  ackv;
  logic        hold, agu_req, ld_req, alu_req, st_req, iop_retire, busy;
  logic [31:0] iop_out;

  tok_t        exp_q[$];
  logic [31:0] mq_iop[$];
  logic [2:0]  mq_init[$];
  int          head_k = 0;
  bit          exp_ret = 1'b0;
  bit          mon_en = 1'b0;
  int          checks = 0, failures = 0, ret_cnt = 0;

  iop_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .id_feed(id_feed), .id_iop(id_iop), .id_iop_init(id_iop_init),
    .hold(hold), .flush(flush), .iop_out(iop_out),
    .agu_req(agu_req), .agu_ack(ackv[0]), .ld_req(ld_req), .ld_ack(ackv[1]),
    .alu_req(alu_req), .alu_ack(ackv[2]), .st_req(st_req), .st_ack(ackv[3]),
    .iop_retire(iop_retire), .busy(busy)
  );

  always #5 clk = ~clk;

  // route of an iop as an ordered list of steps, ending in K_RET
  function automatic int step_at(input logic [31:0] iop, input logic [2:0] init, input int k);
    int s[4];
    int n;
    n = 0;
    s = '{default: K_NONE};
    if (init[0]) begin
      s[n] = K_AGU; n++;
      if (iop[22] && !iop[4]) begin s[n] = K_ALU; n++; end
      else begin s[n] = K_LD; n++; s[n] = K_ALU; n++; end
    end else if (init[1]) begin
      s[n] = K_ALU; n++;
    end else begin
      s[n] = K_LD; n++; s[n] = K_ALU; n++;
    end
    if (iop[22]) begin s[n] = K_ST; n++; end
    if (k >= n) return K_RET;
    return s[k];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input bit r, input bit fl, input bit feed, input logic [31:0] iop,
                       input logic [2:0] init, input logic [3:0] ack);
    tok_t t;
    int   kd;
    rst = r; flush = fl; id_feed = feed; id_iop = iop; id_iop_init = init; ackv = ack;
    if (!r && !fl && feed && init[2] && mq_iop.size() < DEPTH) begin
      for (int k = 0; k < 5; k++) begin
        kd = step_at(iop, init, k);
        t.iop = iop;
        t.kind = kd;
        exp_q.push_back(t);
        if (kd == K_RET) break;
      end
    end
  endtask

  task automatic model_update();
    bit acc, bp, ret;
    int kd;
    if (rst || flush) begin
      mq_iop.delete(); mq_init.delete(); exp_q.delete();
      head_k = 0; exp_ret = 1'b0;
      return;
    end
    acc = id_feed && id_iop_init[2] && (mq_iop.size() < DEPTH);
    bp  = BYP && acc && (mq_iop.size() == 0) && (id_iop_init[1:0] == 2'b10);
    if (bp) begin
      mq_iop.push_back(id_iop); mq_init.push_back(id_iop_init);
      head_k = 0; acc = 1'b0;
    end
    ret = 1'b0;
    if (mq_iop.size() > 0) begin
      kd = step_at(mq_iop[0], mq_init[0], head_k);
      if (ackv[kd]) begin
        head_k++;
        if (step_at(mq_iop[0], mq_init[0], head_k) == K_RET) begin
          void'(mq_iop.pop_front()); void'(mq_init.pop_front());
          head_k = 0; ret = 1'b1;
        end
      end
    end
    if (acc) begin mq_iop.push_back(id_iop); mq_init.push_back(id_iop_init); end
    exp_ret = ret;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle(input int n, input logic [3:0] ack);
    for (int i = 0; i < n; i++) begin
      apply(0, 0, 0, 32'h0, 3'b000, ack);
      tick();
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] ei;
    logic [3:0]  ereq, req;
    int          ek, hk;
    bit          bp;
    if (mon_en) begin
      req = {st_req, alu_req, ld_req, agu_req};
      bp  = BYP && !rst && !flush && (mq_iop.size() == 0) && id_feed && (id_iop_init == 3'b110);
      if (bp) begin ei = id_iop; ek = K_ALU; end
      else if (mq_iop.size() > 0) begin ei = mq_iop[0]; ek = step_at(mq_iop[0], mq_init[0], head_k); end
      else begin ei = 32'h0; ek = K_NONE; end
      ereq = (ek < 4) ? (4'b0001 << ek) : 4'b0000;
      check("iop_out", iop_out, ei);
      check("reqs", {28'h0, req}, {28'h0, ereq});
      check("busy", 32'(busy), 32'(mq_iop.size() > 0));
      check("hold", 32'(hold), 32'(mq_iop.size() == DEPTH));
      check("iop_retire", 32'(iop_retire), 32'(exp_ret));
      if (iop_retire) begin
        ret_cnt++;
        checks++;
        if (exp_q.size() == 0 || exp_q[0].kind != K_RET) begin
          failures++;
          $display("FAIL sb_retire: retire seen, expected next token kind %0d",
                   (exp_q.size() == 0) ? K_NONE : exp_q[0].kind);
        end else begin
          void'(exp_q.pop_front());
        end
      end
      if (!rst && !flush && ((req & ackv) != 4'b0000)) begin
        hk = req[0] ? K_AGU : req[1] ? K_LD : req[2] ? K_ALU : K_ST;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_step: handshake kind %0d iop %h, expected none", hk, iop_out);
        end else begin
          if (exp_q[0].kind != hk || exp_q[0].iop !== iop_out) begin
            failures++;
            $display("FAIL sb_step: got kind %0d iop %h expected kind %0d iop %h",
                     hk, iop_out, exp_q[0].kind, exp_q[0].iop);
          end
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int          r0;
    logic [31:0] w;
    logic [2:0]  in;
    logic [3:0]  a;
    bit          f, fl;

    // reset for two cycles
    apply(1, 0, 0, 32'h0, 3'b000, 4'b0000);
    tick();
    mon_en = 1'b1;
    tick();
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_hold", 32'(hold), 32'h0);

    // ALU-only iop with alu_ack tied high
    r0 = ret_cnt;
    apply(0, 0, 1, 32'h0000_1234, 3'b110, 4'b0100);
    @(negedge clk);
    check("alu_req_push_cycle", 32'(alu_req), 32'(BYP));
    tick();
    check("retire_after_push_edge", 32'(iop_retire), 32'(BYP));
    idle(3, 4'b0100);
    check("alu_only_retires", 32'(ret_cnt - r0), 32'd1);
    check("alu_only_busy_end", 32'(busy), 32'h0);

    // indexed RMW, each ack two cycles late
    r0 = ret_cnt;
    apply(0, 0, 1, 32'h8140_2210, 3'b101, 4'b0000);
    tick();
    for (int s = 0; s < 4; s++) begin
      idle(2, 4'b0000);
      if (s == K_ST) begin
        @(negedge clk);
        check("rmw_st_req", 32'(st_req), 32'h1);
        check("rmw_bit4_in_store", 32'(iop_out[4]), 32'h1);
      end
      apply(0, 0, 0, 32'h0, 3'b000, 4'(4'b0001 << s));
      tick();
    end
    idle(2, 4'b0000);
    check("rmw_retires", 32'(ret_cnt - r0), 32'd1);

    // fill to full, then push and retire together
    r0 = ret_cnt;
    for (int i = 0; i < 5; i++) begin
      apply(0, 0, 1, 32'hA000_0000 + 32'(i), 3'b110, 4'b0000);
      tick();
    end
    check("fill_hold", 32'(hold), 32'h1);
    for (int i = 0; i < 6; i++) begin
      apply(0, 0, 1, 32'hB000_0000 + 32'(i), 3'b110, 4'b0100);
      tick();
    end
    idle(10, 4'b0100);
    check("fill_retires", 32'(ret_cnt - r0), 32'd9);
    check("fill_busy_end", 32'(busy), 32'h0);

    // invalid push and stray ack
    apply(0, 0, 1, 32'hDEAD_BEEF, 3'b010, 4'b0000);
    tick();
    check("invalid_dropped", 32'(busy), 32'h0);
    apply(0, 0, 1, 32'h0040_0000, 3'b110, 4'b0000);
    tick();
    apply(0, 0, 0, 32'h0, 3'b000, 4'b1000);
    tick();
    check("stray_st_ack_alu_req", 32'(alu_req), 32'h1);
    check("stray_st_ack_st_req", 32'(st_req), 32'h0);
    idle(1, 4'b0100);
    idle(3, 4'b1000);

    // flush with head in LOAD, colliding with a push and ld_ack
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 1, 32'hC000_0000 + 32'(i), 3'b100, 4'b0000);
      tick();
    end
    apply(0, 1, 1, 32'h5555_0000, 3'b110, 4'b0010);
    tick();
    check("flush_busy", 32'(busy), 32'h0);
    check("flush_reqs", {28'h0, st_req, alu_req, ld_req, agu_req}, 32'h0);
    check("flush_no_retire", 32'(iop_retire), 32'h0);
    check("flush_iop_out", iop_out, 32'h0);
    idle(2, 4'b0000);
    check("flush_push_discarded", 32'(busy), 32'h0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      w  = $urandom;
      in = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) != 0) in[2] = 1'b1;
      f  = ($urandom_range(0, 2) != 0);
      a  = 4'($urandom);
      fl = ($urandom_range(0, 99) == 0);
      apply(0, fl, f, w, in, a);
      tick();
    end
    idle(30, 4'b1111);
    check("drain_busy", 32'(busy), 32'h0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
